// File: rtl/rc5_crypt_engine.sv
// rc5_crypt_engine: RC5-W/R/B key expansion with one-block-at-a-time encrypt/decrypt.
// Build option RC5_ZEROIZE_EN adds a zeroize input that wipes all key material.
module rc5_crypt_engine #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int B = 16,
    parameter logic [W-1:0] PW = 32'hB7E15163,
    parameter logic [W-1:0] QW = 32'h9E3779B9,
    localparam int KAW = (B > 1) ? $clog2(B) : 1
) (
    input  logic           clk,
    input  logic           rst,
`ifdef RC5_ZEROIZE_EN
    input  logic           zeroize,
`endif
    input  logic           key_wr,
    input  logic [KAW-1:0] key_addr,
    input  logic [7:0]     key_byte,
    input  logic           key_start,
    output logic           key_ready,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   A_out,
    output logic [W-1:0]   B_out
);

    localparam int WB   = W / 8;
    localparam int LW   = $clog2(W);
    localparam int T    = 2 * (R + 1);
    localparam int C    = (B + WB - 1) / WB;
    localparam int KP   = C * WB;
    localparam int NMIX = 3 * ((T > C) ? T : C);
    localparam int TW   = $clog2(T);
    localparam int CW   = (C > 1) ? $clog2(C) : 1;
    localparam int NW   = $clog2(NMIX + 1);

    typedef enum logic [2:0] {
        IDLE, S_INIT, MIX, ENC_PRE, ENC_RND, DEC_RND, DEC_POST
    } state_t;

    state_t state, state_n;

    logic zz;
`ifdef RC5_ZEROIZE_EN
    assign zz = zeroize;
`else
    assign zz = 1'b0;
`endif

    logic [7:0]   kmem   [KP];
    logic [W-1:0] s_tab  [T];
    logic [W-1:0] l_tab  [C];
    logic [W-1:0] l_init [C];

    logic [NW-1:0] cnt;
    logic [TW-1:0] mi;
    logic [CW-1:0] mj;
    logic [W-1:0]  sval, ma, mb, ra, rb;
    logic [7:0]    rk;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                          input logic [W-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n[LW-1:0];
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x,
                                          input logic [W-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n[LW-1:0];
        return t[W-1:0];
    endfunction

    logic idle, acc, ks_go, init_last, mix_last;

    assign idle      = state == IDLE;
    assign in_ready  = idle & key_ready & ~out_valid;
    assign acc       = in_valid & in_ready;
    assign ks_go     = key_start & idle & ~out_valid & ~acc;
    assign init_last = cnt == NW'(T - 1);
    assign mix_last  = cnt == NW'(NMIX - 1);

    logic [W-1:0] mix_a, mix_ab, mix_b;

    assign mix_a  = rotl(s_tab[mi] + ma + mb, W'(3));
    assign mix_ab = mix_a + mb;
    assign mix_b  = rotl(l_tab[mj] + mix_ab, mix_ab);

    logic [TW-1:0] ix0, ix1;
    logic [W-1:0]  enc_a, enc_b, dec_a, dec_b;

    assign ix0   = TW'({rk, 1'b0});
    assign ix1   = TW'({rk, 1'b1});
    assign enc_a = rotl(ra ^ rb, rb) + s_tab[ix0];
    assign enc_b = rotl(rb ^ enc_a, enc_a) + s_tab[ix1];
    assign dec_b = rotr(rb - s_tab[ix1], ra) ^ ra;
    assign dec_a = rotr(ra - s_tab[ix0], dec_b) ^ dec_b;

    // Unused high bytes of the last L word come out as zero.
    always_comb begin
        for (int j = 0; j < C; j++) begin
            l_init[j] = '0;
            for (int k = 0; k < WB; k++)
                if (j * WB + k < B)
                    l_init[j][k*8 +: 8] = kmem[j * WB + k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (zz) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (acc)        state_n = mode ? DEC_RND : ENC_PRE;
                    else if (ks_go) state_n = S_INIT;
                end
                S_INIT:   if (init_last) state_n = MIX;
                MIX:      if (mix_last) state_n = IDLE;
                ENC_PRE:  state_n = ENC_RND;
                ENC_RND:  if (rk == 8'(R)) state_n = IDLE;
                DEC_RND:  if (rk == 8'd1) state_n = DEC_POST;
                DEC_POST: state_n = IDLE;
                default:  state_n = IDLE;
            endcase
        end
    end

    // Key storage has no reset; only zeroize clears it.
    always_ff @(posedge clk) begin
        if (zz) begin
            for (int i = 0; i < KP; i++) kmem[i] <= '0;
            for (int i = 0; i < T; i++) s_tab[i] <= '0;
            for (int i = 0; i < C; i++) l_tab[i] <= '0;
        end else begin
            if (key_wr && state != S_INIT && state != MIX && 32'(key_addr) < B)
                kmem[key_addr] <= key_byte;
            if (ks_go)
                for (int i = 0; i < C; i++) l_tab[i] <= l_init[i];
            if (state == S_INIT)
                s_tab[TW'(cnt)] <= sval;
            if (state == MIX) begin
                s_tab[mi] <= mix_a;
                l_tab[mj] <= mix_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ready <= 1'b0; out_valid <= 1'b0;
            A_out <= '0; B_out <= '0;
            cnt <= '0; mi <= '0; mj <= '0; rk <= '0;
            sval <= '0; ma <= '0; mb <= '0; ra <= '0; rb <= '0;
        end else if (zz) begin
            key_ready <= 1'b0; out_valid <= 1'b0;
            A_out <= '0; B_out <= '0;
            cnt <= '0; mi <= '0; mj <= '0; rk <= '0;
            sval <= '0; ma <= '0; mb <= '0; ra <= '0; rb <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        ra <= A;
                        rb <= B_in;
                        rk <= 8'(R);
                    end else if (ks_go) begin
                        key_ready <= 1'b0;
                        cnt <= '0;
                        sval <= PW;
                    end
                end
                S_INIT: begin
                    sval <= sval + QW;
                    cnt <= cnt + 1'b1;
                    if (init_last) begin
                        cnt <= '0; mi <= '0; mj <= '0;
                        ma <= '0; mb <= '0;
                    end
                end
                MIX: begin
                    ma <= mix_a;
                    mb <= mix_b;
                    mi <= (mi == TW'(T - 1)) ? '0 : mi + 1'b1;
                    mj <= (mj == CW'(C - 1)) ? '0 : mj + 1'b1;
                    cnt <= cnt + 1'b1;
                    if (mix_last) key_ready <= 1'b1;
                end
                ENC_PRE: begin
                    ra <= ra + s_tab[0];
                    rb <= rb + s_tab[1];
                    rk <= 8'd1;
                end
                ENC_RND: begin
                    ra <= enc_a;
                    rb <= enc_b;
                    rk <= rk + 8'd1;
                    if (rk == 8'(R)) begin
                        A_out <= enc_a;
                        B_out <= enc_b;
                        out_valid <= 1'b1;
                    end
                end
                DEC_RND: begin
                    ra <= dec_a;
                    rb <= dec_b;
                    rk <= rk - 8'd1;
                end
                DEC_POST: begin
                    A_out <= ra - s_tab[0];
                    B_out <= rb - s_tab[1];
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_crypt_engine.sv
// tb_rc5_crypt_engine: scoreboard bench for rc5_crypt_engine (RC5-32/12/16).
// Known vectors, random blocks against a behavioural model, flow control and abort cases.
module tb_rc5_crypt_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_wr;
    logic [3:0]  key_addr;
    logic [7:0]  key_byte;
    logic        key_start;
    logic        key_ready;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] A, B_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A_out, B_out;
`ifdef RC5_ZEROIZE_EN
    logic        zeroize;
`endif

    always #5 clk = ~clk;

    rc5_crypt_engine dut (
        .clk(clk), .rst(rst),
`ifdef RC5_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_wr(key_wr), .key_addr(key_addr), .key_byte(key_byte),
        .key_start(key_start), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .A(A), .B_in(B_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_out(A_out), .B_out(B_out)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct { logic [31:0] a; logic [31:0] b; } blk_t;
    blk_t sb[$];

    logic [7:0]  k0 [16];
    logic [7:0]  k2 [16];
    logic [31:0] ms [26];

    function automatic logic [31:0] rl(input logic [31:0] x, input logic [31:0] s);
        int n = int'(s[4:0]);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input logic [31:0] s);
        int n = int'(s[4:0]);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic model_key(input logic [7:0] kb [16]);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int k = 0; k < 4; k++) l[k] = 0;
        for (int k = 15; k >= 0; k--) l[k/4] = (l[k/4] << 8) + {24'd0, kb[k]};
        ms[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) ms[k] = ms[k-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            a = rl(ms[i] + a + b, 3);
            ms[i] = a;
            b = rl(l[j] + a + b, a + b);
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [63:0] m_enc(input logic [31:0] a, input logic [31:0] b);
        a = a + ms[0];
        b = b + ms[1];
        for (int k = 1; k <= 12; k++) begin
            a = rl(a ^ b, b) + ms[2*k];
            b = rl(b ^ a, a) + ms[2*k+1];
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] m_dec(input logic [31:0] a, input logic [31:0] b);
        for (int k = 12; k >= 1; k--) begin
            b = rr(b - ms[2*k+1], a) ^ a;
            a = rr(a - ms[2*k], b) ^ b;
        end
        return {a - ms[0], b - ms[1]};
    endfunction

    task automatic write_key(input logic [7:0] kb [16]);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            key_wr = 1'b1;
            key_addr = 4'(i);
            key_byte = kb[i];
        end
        @(negedge clk);
        key_wr = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] kb [16], input string tag);
        int n;
        write_key(kb);
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        check({tag, "_kr_clr"}, key_ready, 0);
        n = 0;
        while (!key_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_key_lat"}, n, 104);
    endtask

    task automatic run_block(input logic m, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ea, input logic [31:0] eb,
                             input string tag, input bit poke_ks, input int hold);
        int w, lat;
        bit ok;
        blk_t e;
        logic [63:0] snap;
        sb.push_back('{ea, eb});
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check({tag, "_rdy"}, 0, 1);
            void'(sb.pop_back());
            return;
        end
        mode = m; A = a; B_in = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (poke_ks) key_start = 1'b1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            key_start = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, lat, 13);
        e = sb.pop_front();
        check({tag, "_a"}, A_out, e.a);
        check({tag, "_b"}, B_out, e.b);
        if (poke_ks) check({tag, "_ks_ignored"}, key_ready, 1);
        if (hold > 0) begin
            ok = 1;
            snap = {A_out, B_out};
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                key_start = (i == 5);
                if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                    key_ready !== 1'b1 || {A_out, B_out} !== snap) ok = 0;
            end
            key_start = 1'b0;
            check({tag, "_hold"}, ok, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, out_valid, 0);
        check({tag, "_in_rdy"}, in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        logic [31:0] pa, pb;
        logic [63:0] e;
        rst = 1'b1; key_wr = 0; key_addr = 0; key_byte = 0; key_start = 0;
        in_valid = 0; mode = 0; A = 0; B_in = 0; out_ready = 0;
`ifdef RC5_ZEROIZE_EN
        zeroize = 0;
`endif
        for (int i = 0; i < 16; i++) k0[i] = 8'h00;
        k2 = '{8'h91, 8'h5F, 8'h46, 8'h19, 8'hBE, 8'h41, 8'hB2, 8'h51,
               8'h63, 8'h55, 8'hA5, 8'h01, 8'h10, 8'hA9, 8'hCE, 8'h91};
        repeat (3) @(negedge clk);
        check("rst_key_ready", key_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_A_out", A_out, 0);
        check("rst_B_out", B_out, 0);
        rst = 1'b0;

        in_valid = 1'b1; A = 32'h1234_5678; B_in = 32'h9abc_def0;
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) ok = 0;
        end
        in_valid = 1'b0;
        check("early_no_accept", ok, 1);

        load_key(k0, "k0");
        run_block(0, 32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15, "v1", 0, 0);

        load_key(k2, "k2");
        model_key(k2);
        run_block(0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B, "v2_enc", 0, 0);
        run_block(1, 32'hAC13C0F7, 32'h52892B5B, 32'hEEDBA521, 32'h6D8F4B15, "v2_dec", 0, 20);
        run_block(0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B, "v2_ks", 1, 0);
        run_block(0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B, "v2_rerun", 0, 0);

        for (int i = 0; i < 3; i++) begin
            pa = $urandom; pb = $urandom;
            e = m_enc(pa, pb);
            run_block(0, pa, pb, e[63:32], e[31:0], "rnd_enc", 0, 0);
            pa = $urandom; pb = $urandom;
            e = m_dec(pa, pb);
            run_block(1, pa, pb, e[63:32], e[31:0], "rnd_dec", 0, 0);
        end

        write_key(k0);
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        repeat (75) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_key_ready", key_ready, 0);
        check("abort_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        load_key(k0, "k0_again");
        run_block(0, 32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15, "v1_after_rst", 0, 0);

`ifdef RC5_ZEROIZE_EN
        mode = 0; A = 0; B_in = 0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("zz_pre_ov", out_valid, 1);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check("zz_out_valid", out_valid, 0);
        check("zz_key_ready", key_ready, 0);
        check("zz_outputs", {A_out, B_out}, 64'h0);
        load_key(k0, "k0_zz");
        run_block(0, 32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15, "v1_after_zz", 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
